// File: rtl/tick_sched.sv
// Shared-timebase timer scheduler: NREQ requesters share one prescaler and one
// tick down-counter, granted round-robin; completion or early release is pulsed back.
module tick_sched #(
  parameter int NREQ     = 4,
  parameter int DUR_W    = 8,
  parameter int TICK_DIV = 10_000_000
) (
  input  logic                    clk_100MHz,
  input  logic                    reset,
  input  logic [NREQ-1:0]         req,
  input  logic [NREQ*DUR_W-1:0]   dur,
  output logic [NREQ-1:0]         grant,
  output logic                    busy,
  output logic                    tick,
  output logic [NREQ-1:0]         done,
  output logic [NREQ-1:0]         abort
);

  localparam int            PW   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int            IW   = $clog2(NREQ);
  localparam logic [PW-1:0] PMAX = PW'(TICK_DIV - 1);

  typedef enum logic [2:0] {IDLE, LOAD, RUN, DONE, ABRT} state_t;

  state_t            state_q;
  logic [PW-1:0]     presc_q;
  logic [DUR_W-1:0]  remaining_q;
  logic [IW-1:0]     ptr_q;
  logic [IW-1:0]     owner_q;
  logic [NREQ-1:0]   grant_q;

  logic [IW-1:0]     pick_idx;
  logic              pick_valid;
  logic [DUR_W-1:0]  owner_dur;
  logic              wrap;
  logic [IW-1:0]     ptr_d;

  // Scan downward so the request closest to the pointer is the last (winning) assignment.
  always_comb begin
    int j;
    j          = 0;
    pick_idx   = '0;
    pick_valid = 1'b0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      j = int'(ptr_q) + i;
      if (j >= NREQ) j = j - NREQ;
      if (req[j]) begin
        pick_idx   = IW'(j);
        pick_valid = 1'b1;
      end
    end
  end

  assign owner_dur = dur[owner_q*DUR_W +: DUR_W];
  assign wrap      = (presc_q == PMAX);
  assign ptr_d     = (owner_q == IW'(NREQ - 1)) ? '0 : owner_q + 1'b1;

  always_ff @(posedge clk_100MHz or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      presc_q     <= '0;
      remaining_q <= '0;
      ptr_q       <= '0;
      owner_q     <= '0;
      grant_q     <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (pick_valid) begin
            owner_q <= pick_idx;
            grant_q <= NREQ'(1) << pick_idx;
            state_q <= LOAD;
          end
        end
        LOAD: begin
          remaining_q <= owner_dur;
          presc_q     <= '0;
          state_q     <= (owner_dur == '0) ? DONE : RUN;
        end
        RUN: begin
          // A dropped request wins over a final tick in the same cycle.
          if (!req[owner_q]) begin
            state_q <= ABRT;
          end else begin
            presc_q <= wrap ? '0 : presc_q + 1'b1;
            if (wrap) begin
              remaining_q <= remaining_q - 1'b1;
              if (remaining_q == DUR_W'(1)) state_q <= DONE;
            end
          end
        end
        DONE, ABRT: begin
          ptr_q   <= ptr_d;
          grant_q <= '0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign grant = grant_q;
  assign busy  = (state_q != IDLE);
  assign tick  = (state_q == RUN) && wrap;

  for (genvar gi = 0; gi < NREQ; gi++) begin : g_pulse
    assign done[gi]  = (state_q == DONE) && grant_q[gi];
    assign abort[gi] = (state_q == ABRT) && grant_q[gi];
  end

endmodule

// File: tb/tb_tick_sched.sv
// Self-checking bench for tick_sched (TICK_DIV=4): done/abort pulses are
// scoreboarded; grant, tick and busy timing are checked inline per scenario.
module tb_tick_sched;

  logic        clk;
  logic        reset;
  logic [3:0]  req;
  logic [31:0] dur;
  logic [3:0]  grant;
  logic        busy;
  logic        tick;
  logic [3:0]  done;
  logic [3:0]  abort;

  int checks   = 0;
  int errors   = 0;
  int cyc      = 0;
  int tick_cnt = 0;

  typedef struct {
    bit         is_abort;
    logic [3:0] mask;
    int         cyc;
  } exp_t;
  exp_t sb[$];
  exp_t mon_e;

  tick_sched #(.NREQ(4), .DUR_W(8), .TICK_DIV(4)) dut (
    .clk_100MHz (clk),
    .reset      (reset),
    .req        (req),
    .dur        (dur),
    .grant      (grant),
    .busy       (busy),
    .tick       (tick),
    .done       (done),
    .abort      (abort)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboard monitor: every done/abort pulse must match the oldest expectation.
  always @(negedge clk) begin
    if (!reset) begin
      if (tick) tick_cnt++;
      if (busy) begin
        checks++;
        if (!$onehot(grant)) begin
          errors++;
          $display("FAIL grant_onehot cyc=%0d grant=%b", cyc, grant);
        end
      end
      if ((done | abort) != 4'b0) begin
        checks++;
        if (done != 4'b0 && abort != 4'b0) begin
          errors++;
          $display("FAIL done_abort_both cyc=%0d done=%b abort=%b", cyc, done, abort);
        end else if (sb.size() == 0) begin
          errors++;
          $display("FAIL unexpected_pulse cyc=%0d done=%b abort=%b", cyc, done, abort);
        end else begin
          mon_e = sb.pop_front();
          if ((abort != 4'b0) !== mon_e.is_abort || (done | abort) !== mon_e.mask ||
              (mon_e.cyc >= 0 && cyc != mon_e.cyc)) begin
            errors++;
            $display("FAIL pulse cyc=%0d done=%b abort=%b, expected %s mask=%b at cyc=%0d",
                     cyc, done, abort, mon_e.is_abort ? "abort" : "done", mon_e.mask, mon_e.cyc);
          end else begin
            $display("pulse ok cyc=%0d %s=%b", cyc, mon_e.is_abort ? "abort" : "done", mon_e.mask);
          end
        end
      end
    end
  end

  task automatic push_exp(input bit is_abort, input logic [3:0] mask, input int at);
    exp_t e;
    e.is_abort = is_abort;
    e.mask     = mask;
    e.cyc      = at;
    sb.push_back(e);
  endtask

  // Waits (bounded) for the next done/abort pulse; returns at that cycle's negedge.
  task automatic wait_pulse(input string name, output bit ok);
    ok = 1'b0;
    for (int n = 0; n < 100; n++) begin
      @(negedge clk);
      if ((done | abort) != 4'b0) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL %s timeout: no done/abort within 100 cycles", name);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    req   = 4'b0;
    dur   = 32'b0;
    repeat (2) @(negedge clk);
    checks += 5;
    if (grant !== 4'b0) begin errors++; $display("FAIL reset_grant got=%b exp=0000", grant); end
    if (busy  !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", busy); end
    if (tick  !== 1'b0) begin errors++; $display("FAIL reset_tick got=%b exp=0", tick); end
    if (done  !== 4'b0) begin errors++; $display("FAIL reset_done got=%b exp=0000", done); end
    if (abort !== 4'b0) begin errors++; $display("FAIL reset_abort got=%b exp=0000", abort); end
    reset = 1'b0;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL reset_idle busy got=%b exp=0", busy); end
    $display("test_reset done");
  endtask

  task automatic test_rotation();
    bit ok;
    logic [3:0] exp_g;
    @(posedge clk); #1;
    dur = 32'h01010101;
    req = 4'b1111;
    for (int o = 0; o < 4; o++) push_exp(1'b0, 4'(1 << o), -1);
    for (int o = 0; o < 4; o++) begin
      wait_pulse("rotation", ok);
      if (ok) begin
        exp_g = 4'(1 << o);
        checks++;
        if (grant !== exp_g) begin
          errors++;
          $display("FAIL rotation_order step=%0d got=%b exp=%b", o, grant, exp_g);
        end
      end
      req[o] = 1'b0;
    end
    @(posedge clk); #1;
    req = 4'b1001;
    push_exp(1'b0, 4'b0001, -1);
    push_exp(1'b0, 4'b1000, -1);
    wait_pulse("rotation_wrap", ok);
    checks++;
    if (grant !== 4'b0001) begin errors++; $display("FAIL rotation_wrap got=%b exp=0001", grant); end
    req[0] = 1'b0;
    wait_pulse("rotation_wrap2", ok);
    checks++;
    if (grant !== 4'b1000) begin errors++; $display("FAIL rotation_wrap2 got=%b exp=1000", grant); end
    req = 4'b0;
    repeat (2) @(negedge clk);
    $display("test_rotation done");
  endtask

  task automatic test_fairness();
    bit ok;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    dur = 32'h01010101;
    req = 4'b0101;
    push_exp(1'b0, 4'b0001, -1);
    push_exp(1'b0, 4'b0100, -1);
    push_exp(1'b0, 4'b0001, -1);
    wait_pulse("fair_first", ok);
    checks++;
    if (grant !== 4'b0001) begin errors++; $display("FAIL fair_first got=%b exp=0001", grant); end
    wait_pulse("fair_second", ok);
    checks++;
    if (grant !== 4'b0100) begin errors++; $display("FAIL fair_second got=%b exp=0100", grant); end
    req[2] = 1'b0;
    wait_pulse("fair_third", ok);
    checks++;
    if (grant !== 4'b0001) begin errors++; $display("FAIL fair_third got=%b exp=0001", grant); end
    req = 4'b0;
    repeat (2) @(negedge clk);
    $display("test_fairness done");
  endtask

  task automatic test_single();
    int c0;
    logic [3:0] exp_g;
    logic exp_t_v, exp_b;
    @(posedge clk); #1;
    dur[7:0] = 8'd3;
    req      = 4'b0001;
    c0       = cyc;
    push_exp(1'b0, 4'b0001, c0 + 14);
    for (int k = 0; k <= 16; k++) begin
      @(negedge clk);
      exp_g   = (k >= 1 && k <= 14) ? 4'b0001 : 4'b0000;
      exp_b   = (k >= 1 && k <= 14);
      exp_t_v = (k == 5 || k == 9 || k == 13);
      checks += 3;
      if (grant !== exp_g) begin errors++; $display("FAIL single_grant k=%0d got=%b exp=%b", k, grant, exp_g); end
      if (busy !== exp_b) begin errors++; $display("FAIL single_busy k=%0d got=%b exp=%b", k, busy, exp_b); end
      if (tick !== exp_t_v) begin errors++; $display("FAIL single_tick k=%0d got=%b exp=%b", k, tick, exp_t_v); end
      if (k == 14) req = 4'b0;
    end
    $display("test_single done");
  endtask

  task automatic test_zero();
    int c0, t0;
    logic [3:0] exp_g;
    @(posedge clk); #1;
    dur[15:8] = 8'd0;
    req       = 4'b0010;
    c0        = cyc;
    t0        = tick_cnt;
    push_exp(1'b0, 4'b0010, c0 + 2);
    for (int k = 0; k <= 4; k++) begin
      @(negedge clk);
      exp_g = (k == 1 || k == 2) ? 4'b0010 : 4'b0000;
      checks++;
      if (grant !== exp_g) begin errors++; $display("FAIL zero_grant k=%0d got=%b exp=%b", k, grant, exp_g); end
      if (k == 2) req = 4'b0;
    end
    checks++;
    if (tick_cnt !== t0) begin errors++; $display("FAIL zero_tick ticks=%0d exp=0", tick_cnt - t0); end
    $display("test_zero done");
  endtask

  task automatic test_abort();
    int c0;
    bit ok;
    @(posedge clk); #1;
    dur[7:0] = 8'd5;
    req      = 4'b0001;
    c0       = cyc;
    push_exp(1'b1, 4'b0001, c0 + 8);
    for (int k = 0; k <= 10; k++) begin
      @(negedge clk);
      if (k == 8) begin
        checks++;
        if (grant !== 4'b0001) begin errors++; $display("FAIL abort_grant8 got=%b exp=0001", grant); end
      end
      if (k == 9) begin
        checks += 2;
        if (grant !== 4'b0000) begin errors++; $display("FAIL abort_grant9 got=%b exp=0000", grant); end
        if (busy !== 1'b0) begin errors++; $display("FAIL abort_busy9 got=%b exp=0", busy); end
      end
      if (k == 7) req = 4'b0;
    end
    // Pointer must now be 1: requester 1 beats requester 0.
    dur = 32'h01010101;
    req = 4'b0011;
    push_exp(1'b0, 4'b0010, -1);
    push_exp(1'b0, 4'b0001, -1);
    wait_pulse("abort_ptr", ok);
    checks++;
    if (grant !== 4'b0010) begin errors++; $display("FAIL abort_ptr got=%b exp=0010", grant); end
    req[1] = 1'b0;
    wait_pulse("abort_ptr2", ok);
    checks++;
    if (grant !== 4'b0001) begin errors++; $display("FAIL abort_ptr2 got=%b exp=0001", grant); end
    req = 4'b0;
    repeat (2) @(negedge clk);
    $display("test_abort done");
  endtask

  task automatic test_async_reset();
    int c0;
    bit ok;
    @(posedge clk); #1;
    dur[7:0] = 8'd5;
    req      = 4'b0001;
    repeat (5) @(negedge clk);
    checks++;
    if (busy !== 1'b1) begin errors++; $display("FAIL areset_pre busy got=%b exp=1", busy); end
    #2 reset = 1'b1;
    #1;
    checks += 5;
    if (grant !== 4'b0) begin errors++; $display("FAIL areset_grant got=%b exp=0000", grant); end
    if (busy  !== 1'b0) begin errors++; $display("FAIL areset_busy got=%b exp=0", busy); end
    if (tick  !== 1'b0) begin errors++; $display("FAIL areset_tick got=%b exp=0", tick); end
    if (done  !== 4'b0) begin errors++; $display("FAIL areset_done got=%b exp=0000", done); end
    if (abort !== 4'b0) begin errors++; $display("FAIL areset_abort got=%b exp=0000", abort); end
    req = 4'b0;
    @(negedge clk);
    reset      = 1'b0;
    dur[23:16] = 8'd1;
    req        = 4'b0100;
    c0         = cyc;
    push_exp(1'b0, 4'b0100, c0 + 6);
    @(posedge clk); #1;
    checks++;
    if (grant !== 4'b0100) begin errors++; $display("FAIL areset_regrant got=%b exp=0100", grant); end
    wait_pulse("areset_done", ok);
    req = 4'b0;
    repeat (2) @(negedge clk);
    $display("test_async_reset done");
  endtask

  initial begin
    test_reset();
    test_rotation();
    test_fairness();
    test_single();
    test_zero();
    test_abort();
    test_async_reset();
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_leftover remaining=%0d exp=0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

endmodule
